// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and waits
// out its stall, and hands each instruction (or a misaligned-target fault)
// to decode through a single valid/ready entry register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_cs_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_stall_i,
  input  logic [31:0] rom_dout_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic        id_fault_o
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_fault_q, id_fault_d;

  logic slot_free;
  logic take_redirect;
  logic target_aligned;
  logic capture;

  // The entry register can take a new word if it is empty or drains this edge.
  assign slot_free      = !id_valid_q || id_ready_i;
  // A redirect is ignored only during the single BOOT cycle.
  assign take_redirect  = redirect_i && (state_q != S_BOOT);
  assign target_aligned = (redirect_pc_i[1:0] == 2'b00);
  // A completed ROM access is captured only if nothing flushes it this edge.
  assign capture        = (state_q == S_FETCH) && !rom_stall_i && slot_free && !take_redirect;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: BOOT always advances, redirects pick FETCH or FAULT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH,
      S_FAULT: begin
        if (take_redirect) begin
          state_d = target_aligned ? S_FETCH : S_FAULT;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output logic: the ROM is only requested while fetching.
  always_comb begin
    rom_cs_o = (state_q == S_FETCH);
  end

  // Datapath next values: redirect beats capture, capture beats plain drain.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_fault_d = id_fault_q;
    if (take_redirect) begin
      id_valid_d = 1'b0;
      if (target_aligned) begin
        pc_d = redirect_pc_i;
      end else begin
        id_valid_d = 1'b1;
        id_fault_d = 1'b1;
        id_inst_d  = 32'h0000_0000;
        id_pc_d    = redirect_pc_i;
      end
    end else if (capture) begin
      id_valid_d = 1'b1;
      id_inst_d  = rom_dout_i;
      id_pc_d    = pc_q;
      id_fault_d = 1'b0;
      pc_d       = pc_q + 32'd4;
    end else if (id_valid_q && id_ready_i) begin
      id_valid_d = 1'b0;
    end
  end

  // PC and decode entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= 32'h0000_0000;
      id_pc_q    <= 32'h0000_0000;
      id_fault_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_fault_q <= id_fault_d;
    end
  end

  assign rom_addr_o = {2'b00, pc_q[31:2]};
  assign id_valid_o = id_valid_q;
  assign id_inst_o  = id_inst_q;
  assign id_pc_o    = id_pc_q;
  assign id_fault_o = id_fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a behavioural ROM with random stall
// length, directed scenarios, and a randomized run against a stream model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_cs;
  logic [31:0] rom_addr;
  logic        rom_stall = 1'b1;
  logic [31:0] rom_dout = 32'hDEAD_BEEF;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_cs_o     (rom_cs),
    .rom_addr_o   (rom_addr),
    .rom_stall_i  (rom_stall),
    .rom_dout_i   (rom_dout),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_inst_o    (id_inst),
    .id_pc_o      (id_pc),
    .id_fault_o   (id_fault)
  );

  always #5 clk = ~clk;

  // ROM model: a new address (or a fresh request) stalls 1..4 cycles, then the
  // ack and data stay up for as long as the address is held.
  int          rom_wait = 0;
  logic        rom_have = 1'b0;
  logic [31:0] rom_last = 32'h0;
  always @(negedge clk) begin
    if (!rom_cs) begin
      rom_have = 1'b0;
    end else if (!rom_have || rom_addr != rom_last) begin
      rom_have = 1'b1;
      rom_last = rom_addr;
      rom_wait = int'($urandom_range(4, 1));
    end else if (rom_wait > 0) begin
      rom_wait = rom_wait - 1;
    end
    rom_stall = !(rom_have && rom_wait == 0);
    rom_dout  = rom_stall ? 32'hDEAD_BEEF : mem[rom_last[5:0]];
  end

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return mem[pc[7:2]];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Assert reset away from any edge, release it just after a falling edge.
  task automatic do_reset();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until an entry is visible; stall_at_edge is rom_stall at the edge
  // that produced it.
  task automatic wait_entry(input int budget, output logic got, output logic stall_at_edge,
                            output logic [31:0] pc, output logic [31:0] inst, output logic fault);
    got = 1'b0; stall_at_edge = 1'b1; pc = '0; inst = '0; fault = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      stall_at_edge = rom_stall;
      tick();
      if (id_valid) begin
        got = 1'b1; pc = id_pc; inst = id_inst; fault = id_fault;
      end
    end
  endtask

  task automatic test_reset();
    id_ready = 1'b1; redirect = 1'b0; rst_n = 1'b0;
    tick();
    tick();
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    checks++; if (rom_addr !== (RESET_PC >> 2)) begin errors++; $display("FAIL reset_rom_addr: got %h want %h", rom_addr, RESET_PC >> 2); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst: got %h want 0", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
    checks++; if (id_fault !== 1'b0) begin errors++; $display("FAIL reset_id_fault: got %b want 0", id_fault); end
    rst_n = 1'b1;
    #1;
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL boot_rom_cs: got %b want 0", rom_cs); end
    tick();
    checks++;
    if (rom_cs !== 1'b1 || rom_addr !== (RESET_PC >> 2)) begin
      errors++; $display("FAIL boot_to_fetch: cs=%b addr=%h want cs=1 addr=%h", rom_cs, rom_addr, RESET_PC >> 2);
    end
  endtask

  task automatic test_sequential();
    logic got, st, f;
    logic [31:0] p, ins, exp_pc;
    exp_pc = RESET_PC;
    for (int k = 0; k < 4; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== exp_pc || ins !== rom_word(exp_pc) || f !== 1'b0) begin
        errors++; $display("FAIL seq_entry%0d: got=%b pc=%h inst=%h fault=%b want pc=%h inst=%h fault=0",
                           k, got, p, ins, f, exp_pc, rom_word(exp_pc));
      end
      checks++; if (st !== 1'b0) begin errors++; $display("FAIL seq_stall_edge%0d: stall at capture edge %b want 0", k, st); end
      exp_pc = exp_pc + 32'd4;
      if (k < 3) begin
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL seq_bubble%0d: id_valid=%b want 0", k, id_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic got, st, f;
    logic [31:0] p, ins;
    do_reset();
    tick();
    wait_entry(40, got, st, p, ins, f);
    checks++;
    if (!got || p !== 32'h0 || ins !== 32'h11) begin
      errors++; $display("FAIL bp_first: got=%b pc=%h inst=%h want pc=0 inst=11", got, p, ins);
    end
    id_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if ({id_valid, id_pc, id_inst, id_fault, rom_addr} !== {1'b1, 32'h0, 32'h11, 1'b0, 32'h1}) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b pc=%h inst=%h fault=%b addr=%h want 1/0/11/0/1",
                           i, id_valid, id_pc, id_inst, id_fault, rom_addr);
      end
    end
    id_ready = 1'b1;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== 32'h22) begin
      errors++; $display("FAIL bp_no_bubble: valid=%b pc=%h inst=%h want 1/4/22", id_valid, id_pc, id_inst);
    end
    for (int k = 2; k < 4; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== 32'(k * 4) || ins !== rom_word(32'(k * 4))) begin
        errors++; $display("FAIL bp_after%0d: got=%b pc=%h inst=%h want pc=%h", k, got, p, ins, k * 4);
      end
    end
  endtask

  task automatic test_redirect_mid_stall();
    logic got, st, f;
    logic [31:0] p, ins;
    do_reset();
    tick();
    for (int k = 0; k < 2; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== 32'(k * 4)) begin errors++; $display("FAIL rms_pre%0d: got=%b pc=%h want %h", k, got, p, k * 4); end
    end
    checks++; if (rom_addr !== 32'h2) begin errors++; $display("FAIL rms_addr_before: got %h want 2", rom_addr); end
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h8) begin
      errors++; $display("FAIL rms_flush: valid=%b addr=%h want 0/8", id_valid, rom_addr);
    end
    wait_entry(40, got, st, p, ins, f);
    checks++;
    if (!got || p !== 32'h20 || ins !== mem[8] || f !== 1'b0) begin
      errors++; $display("FAIL rms_target: got=%b pc=%h inst=%h want pc=20 inst=%h", got, p, ins, mem[8]);
    end
  endtask

  task automatic test_redirect_on_completion();
    logic got, st, f, found;
    logic [31:0] p, ins;
    do_reset();
    tick();
    wait_entry(40, got, st, p, ins, f);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (rom_stall === 1'b0 && rom_cs === 1'b1) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL roc_ack_seen: got %b want 1", found); end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h10) begin
      errors++; $display("FAIL roc_discard: valid=%b addr=%h want 0/10", id_valid, rom_addr);
    end
    for (int k = 0; k < 2; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== 32'(32'h40 + k * 4) || ins !== rom_word(32'(32'h40 + k * 4))) begin
        errors++; $display("FAIL roc_resume%0d: got=%b pc=%h inst=%h want pc=%h", k, got, p, ins, 32'h40 + k * 4);
      end
    end
  endtask

  task automatic test_misaligned();
    logic got, st, f;
    logic [31:0] p, ins;
    do_reset();
    tick();
    wait_entry(40, got, st, p, ins, f);
    redirect = 1'b1; redirect_pc = 32'h22; id_ready = 1'b0;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({id_valid, id_fault, id_pc, id_inst, rom_cs} !== {1'b1, 1'b1, 32'h22, 32'h0, 1'b0}) begin
        errors++; $display("FAIL mis_entry%0d: valid=%b fault=%b pc=%h inst=%h cs=%b want 1/1/22/0/0",
                           i, id_valid, id_fault, id_pc, id_inst, rom_cs);
      end
      tick();
    end
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (id_valid !== 1'b0 || rom_cs !== 1'b0) begin
        errors++; $display("FAIL mis_idle%0d: valid=%b cs=%b want 0/0", i, id_valid, rom_cs);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL mis_recover: cs=%b addr=%h want 1/0", rom_cs, rom_addr);
    end
    for (int k = 0; k < 2; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== 32'(k * 4) || ins !== rom_word(32'(k * 4)) || f !== 1'b0) begin
        errors++; $display("FAIL mis_refetch%0d: got=%b pc=%h inst=%h fault=%b want pc=%h", k, got, p, ins, f, k * 4);
      end
    end
  endtask

  task automatic test_wrap();
    logic got, st, f;
    logic [31:0] p, ins, exp_pc;
    do_reset();
    tick();
    wait_entry(40, got, st, p, ins, f);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== exp_pc || ins !== rom_word(exp_pc)) begin
        errors++; $display("FAIL wrap%0d: got=%b pc=%h inst=%h want pc=%h inst=%h", k, got, p, ins, exp_pc, rom_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_async_reset();
    logic got, st, f;
    logic [31:0] p, ins;
    do_reset();
    tick();
    wait_entry(40, got, st, p, ins, f);
    id_ready = 1'b0;
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", id_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_cs, rom_addr, id_valid, id_inst, id_pc, id_fault} !== {1'b0, RESET_PC >> 2, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL ar_immediate: cs=%b addr=%h valid=%b inst=%h pc=%h fault=%b want reset values",
                         rom_cs, rom_addr, id_valid, id_inst, id_pc, id_fault);
    end
    tick();
    rst_n = 1'b1; id_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      wait_entry(40, got, st, p, ins, f);
      checks++;
      if (!got || p !== RESET_PC + 32'(k * 4) || ins !== rom_word(RESET_PC + 32'(k * 4))) begin
        errors++; $display("FAIL ar_restart%0d: got=%b pc=%h inst=%h", k, got, p, ins);
      end
    end
  endtask

  // Random ready/redirect traffic against a stream model: the next expected
  // entry is either the instruction at exp_pc or a pending fault entry.
  task automatic test_random();
    logic        v, f, rdy, rd, in_fault, fault_taken, prev_hold;
    logic [31:0] p, ins, exp_pc, fault_pc, tgt;
    logic [65:0] prev;
    int          xfers;
    do_reset();
    tick();
    exp_pc = RESET_PC; in_fault = 1'b0; fault_taken = 1'b0; fault_pc = '0;
    prev_hold = 1'b0; prev = '0; xfers = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v = id_valid; p = id_pc; ins = id_inst; f = id_fault;
      if (prev_hold) begin
        checks++;
        if ({v, p, ins, f} !== prev) begin errors++; $display("FAIL rnd_hold@%0d: entry changed while stalled", cyc); end
      end
      if (fault_taken) begin
        checks++;
        if (v !== 1'b0) begin errors++; $display("FAIL rnd_fault_idle@%0d: id_valid=%b want 0", cyc, v); end
      end
      rdy = ($urandom_range(99) < 70);
      rd  = ($urandom_range(99) < 4);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(99) < 25) tgt[1:0] = 2'($urandom_range(3, 1));
      id_ready = rdy; redirect = rd; redirect_pc = tgt;
      if (v && rdy && !rd) begin
        checks++;
        xfers++;
        if (in_fault) begin
          if ({f, p, ins} !== {1'b1, fault_pc, 32'h0}) begin
            errors++; $display("FAIL rnd_fault_entry@%0d: fault=%b pc=%h inst=%h want 1/%h/0", cyc, f, p, ins, fault_pc);
          end
          fault_taken = 1'b1;
        end else begin
          if ({f, p, ins} !== {1'b0, exp_pc, rom_word(exp_pc)}) begin
            errors++; $display("FAIL rnd_entry@%0d: fault=%b pc=%h inst=%h want 0/%h/%h", cyc, f, p, ins, exp_pc, rom_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_hold = v && !rdy && !rd;
      prev = {v, p, ins, f};
      if (rd) begin
        fault_taken = 1'b0;
        if (tgt[1:0] == 2'b00) begin
          exp_pc = tgt; in_fault = 1'b0;
        end else begin
          fault_pc = tgt; in_fault = 1'b1;
        end
      end
      tick();
      if (rd) begin
        checks++;
        if (id_valid !== in_fault || rom_cs !== !in_fault) begin
          errors++; $display("FAIL rnd_redirect@%0d: valid=%b cs=%b want %b/%b", cyc, id_valid, rom_cs, in_fault, !in_fault);
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (xfers < 20) begin errors++; $display("FAIL rnd_progress: %0d transfers want at least 20", xfers); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_mid_stall();
    test_redirect_on_completion();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
